// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: shared widths and types for the register file scoreboard
package regfile_scoreboard_pkg;
    localparam int REG_WIDTH  = 16;
    localparam int VREG_WIDTH = 64;
    localparam int NUM_REGS   = 16;
    localparam int REG_IDX_W  = 4;
    localparam int PEND_W     = 2;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [PEND_W-1:0]    pend_t;
    localparam pend_t PEND_MAX = '1;
endpackage

// File: rtl/sb_counter_bank.sv
// sb_counter_bank: per-register pending-write counters with hazard lookup
module sb_counter_bank
    import regfile_scoreboard_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     en_i,
    input  logic     inc_i,
    input  reg_idx_t inc_idx_i,
    input  logic     dec_i,
    input  reg_idx_t dec_idx_i,
    input  reg_idx_t rd1_idx_i,
    input  reg_idx_t rd2_idx_i,
    input  reg_idx_t wr_idx_i,
    output logic     rd1_haz_o,
    output logic     rd2_haz_o,
    output logic     wr_full_o,
    output logic     underflow_o
);
    pend_t cnt_q [NUM_REGS];
    pend_t cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] inc_hot, dec_hot;

    assign inc_hot = (en_i && inc_i) ? NUM_REGS'(1) << inc_idx_i : '0;
    assign dec_hot = (en_i && dec_i) ? NUM_REGS'(1) << dec_idx_i : '0;

    // A pending read is released early only by a writeback to that register in the same cycle.
    assign rd1_haz_o   = cnt_q[rd1_idx_i] > pend_t'(1) ||
                         (cnt_q[rd1_idx_i] == pend_t'(1) && !(dec_i && dec_idx_i == rd1_idx_i));
    assign rd2_haz_o   = cnt_q[rd2_idx_i] > pend_t'(1) ||
                         (cnt_q[rd2_idx_i] == pend_t'(1) && !(dec_i && dec_idx_i == rd2_idx_i));
    assign wr_full_o   = cnt_q[wr_idx_i] == PEND_MAX;
    assign underflow_o = en_i && dec_i && cnt_q[dec_idx_i] == '0;

    // Next count: increment and decrement cancel, both ends saturate
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = (inc_hot[i] && !dec_hot[i] && cnt_q[i] != PEND_MAX) ? cnt_q[i] + pend_t'(1) :
                       (dec_hot[i] && !inc_hot[i] && cnt_q[i] != '0)       ? cnt_q[i] - pend_t'(1) :
                       cnt_q[i];
        end
    end

    // Counter storage with synchronous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: scalar/vector register files with pending-write scoreboard and issue stall
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
(
    input  logic                  I_CLOCK,
    input  logic                  I_RESET,
    input  logic                  I_LOCK,
    input  logic                  I_IssueValid,
    input  logic                  I_DestUsed,
    input  logic                  I_DestVec,
    input  logic [REG_IDX_W-1:0]  I_DestIdx,
    input  logic                  I_Src1Used,
    input  logic                  I_Src1Vec,
    input  logic [REG_IDX_W-1:0]  I_Src1Idx,
    input  logic                  I_Src2Used,
    input  logic                  I_Src2Vec,
    input  logic [REG_IDX_W-1:0]  I_Src2Idx,
    input  logic                  I_WriteBackEnable,
    input  logic                  I_VWriteBackEnable,
    input  logic [5:0]            I_WriteBackRegIdx,
    input  logic [REG_WIDTH-1:0]  I_WriteBackData,
    input  logic [VREG_WIDTH-1:0] I_VWriteBackData,
    output logic [REG_WIDTH-1:0]  O_Src1Data,
    output logic [REG_WIDTH-1:0]  O_Src2Data,
    output logic [VREG_WIDTH-1:0] O_VSrc1Data,
    output logic [VREG_WIDTH-1:0] O_VSrc2Data,
    output logic                  O_DepStall,
    output logic                  O_WBError
);
    logic [REG_WIDTH-1:0]  rf_q  [NUM_REGS];
    logic [VREG_WIDTH-1:0] vrf_q [NUM_REGS];
    logic     wb_err_q, wb_err_d;
    reg_idx_t wb_idx;
    logic     s_rd1_haz, s_rd2_haz, s_full, s_uf;
    logic     v_rd1_haz, v_rd2_haz, v_full, v_uf;
    logic     src1_haz, src2_haz, dest_haz, accept;
    logic     unused_wb_idx_hi;

    assign wb_idx           = I_WriteBackRegIdx[REG_IDX_W-1:0];
    assign unused_wb_idx_hi = ^I_WriteBackRegIdx[5:REG_IDX_W];

    sb_counter_bank u_sbank (
        .clk_i       (I_CLOCK),
        .rst_i       (I_RESET),
        .en_i        (I_LOCK),
        .inc_i       (accept & I_DestUsed & ~I_DestVec),
        .inc_idx_i   (I_DestIdx),
        .dec_i       (I_WriteBackEnable),
        .dec_idx_i   (wb_idx),
        .rd1_idx_i   (I_Src1Idx),
        .rd2_idx_i   (I_Src2Idx),
        .wr_idx_i    (I_DestIdx),
        .rd1_haz_o   (s_rd1_haz),
        .rd2_haz_o   (s_rd2_haz),
        .wr_full_o   (s_full),
        .underflow_o (s_uf)
    );

    sb_counter_bank u_vbank (
        .clk_i       (I_CLOCK),
        .rst_i       (I_RESET),
        .en_i        (I_LOCK),
        .inc_i       (accept & I_DestUsed & I_DestVec),
        .inc_idx_i   (I_DestIdx),
        .dec_i       (I_VWriteBackEnable),
        .dec_idx_i   (wb_idx),
        .rd1_idx_i   (I_Src1Idx),
        .rd2_idx_i   (I_Src2Idx),
        .wr_idx_i    (I_DestIdx),
        .rd1_haz_o   (v_rd1_haz),
        .rd2_haz_o   (v_rd2_haz),
        .wr_full_o   (v_full),
        .underflow_o (v_uf)
    );

    assign src1_haz   = I_Src1Used & (I_Src1Vec ? v_rd1_haz : s_rd1_haz);
    assign src2_haz   = I_Src2Used & (I_Src2Vec ? v_rd2_haz : s_rd2_haz);
    assign dest_haz   = I_DestUsed & (I_DestVec ? v_full : s_full);
    assign O_DepStall = I_IssueValid & (src1_haz | src2_haz | dest_haz);
    assign accept     = I_LOCK & I_IssueValid & ~O_DepStall;

    assign O_Src1Data  = (I_WriteBackEnable && wb_idx == I_Src1Idx) ? I_WriteBackData : rf_q[I_Src1Idx];
    assign O_Src2Data  = (I_WriteBackEnable && wb_idx == I_Src2Idx) ? I_WriteBackData : rf_q[I_Src2Idx];
    assign O_VSrc1Data = (I_VWriteBackEnable && wb_idx == I_Src1Idx) ? I_VWriteBackData : vrf_q[I_Src1Idx];
    assign O_VSrc2Data = (I_VWriteBackEnable && wb_idx == I_Src2Idx) ? I_VWriteBackData : vrf_q[I_Src2Idx];

    assign wb_err_d  = wb_err_q | s_uf | v_uf;
    assign O_WBError = wb_err_q;

    // Register files and sticky writeback-error flag; reset wins over the pipeline lock
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i]  <= '0;
                vrf_q[i] <= '0;
            end
            wb_err_q <= 1'b0;
        end else if (I_LOCK) begin
            if (I_WriteBackEnable) rf_q[wb_idx] <= I_WriteBackData;
            if (I_VWriteBackEnable) vrf_q[wb_idx] <= I_VWriteBackData;
            wb_err_q <= wb_err_d;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: scoreboard-checked bench for regfile_scoreboard
module tb_regfile_scoreboard;
    typedef struct {
        logic        rst, lock, issue, dused, dvec, s1used, s1vec, s2used, s2vec, wbe, vwbe;
        logic [3:0]  didx, s1idx, s2idx, wbidx;
        logic [1:0]  wbhi;
        logic [15:0] wbd;
        logic [63:0] vwbd;
    } stim_t;
    typedef struct {
        logic        stall, err;
        logic [15:0] s1, s2;
        logic [63:0] v1, v2;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t s;
    obs_t  got;
    obs_t  exp_q [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string tag = "init";

    int          cnt [2][16];
    logic [15:0] ms [16];
    logic [63:0] mv [16];
    logic        merr;
    bit          mdl_ok = 0;

    logic [15:0] o_s1, o_s2;
    logic [63:0] o_v1, o_v2;
    logic        o_stall, o_err;

    regfile_scoreboard dut (
        .I_CLOCK            (clk),
        .I_RESET            (s.rst),
        .I_LOCK             (s.lock),
        .I_IssueValid       (s.issue),
        .I_DestUsed         (s.dused),
        .I_DestVec          (s.dvec),
        .I_DestIdx          (s.didx),
        .I_Src1Used         (s.s1used),
        .I_Src1Vec          (s.s1vec),
        .I_Src1Idx          (s.s1idx),
        .I_Src2Used         (s.s2used),
        .I_Src2Vec          (s.s2vec),
        .I_Src2Idx          (s.s2idx),
        .I_WriteBackEnable  (s.wbe),
        .I_VWriteBackEnable (s.vwbe),
        .I_WriteBackRegIdx  ({s.wbhi, s.wbidx}),
        .I_WriteBackData    (s.wbd),
        .I_VWriteBackData   (s.vwbd),
        .O_Src1Data         (o_s1),
        .O_Src2Data         (o_s2),
        .O_VSrc1Data        (o_v1),
        .O_VSrc2Data        (o_v2),
        .O_DepStall         (o_stall),
        .O_WBError          (o_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic stim_t idle();
        stim_t t;
        t = '{default: '0};
        t.lock = 1'b1;
        return t;
    endfunction

    function automatic bit src_haz(input bit vec, input logic [3:0] idx, input stim_t t);
        int c;
        bit hit;
        c   = cnt[vec][idx];
        hit = (vec ? t.vwbe : t.wbe) && t.wbidx == idx;
        return c >= 2 || (c == 1 && !hit);
    endfunction

    function automatic obs_t predict(input stim_t t);
        obs_t o;
        bit   haz;
        haz = (t.s1used && src_haz(t.s1vec, t.s1idx, t)) ||
              (t.s2used && src_haz(t.s2vec, t.s2idx, t)) ||
              (t.dused && cnt[t.dvec][t.didx] == 3);
        o.stall = t.issue && haz;
        o.err   = merr;
        o.s1    = (t.wbe && t.wbidx == t.s1idx) ? t.wbd : ms[t.s1idx];
        o.s2    = (t.wbe && t.wbidx == t.s2idx) ? t.wbd : ms[t.s2idx];
        o.v1    = (t.vwbe && t.wbidx == t.s1idx) ? t.vwbd : mv[t.s1idx];
        o.v2    = (t.vwbe && t.wbidx == t.s2idx) ? t.vwbd : mv[t.s2idx];
        return o;
    endfunction

    task automatic apply(input stim_t t, input bit stall);
        bit inc, dec;
        if (t.rst) begin
            for (int i = 0; i < 16; i++) begin
                cnt[0][i] = 0;
                cnt[1][i] = 0;
                ms[i] = '0;
                mv[i] = '0;
            end
            merr   = 1'b0;
            mdl_ok = 1;
        end else if (t.lock) begin
            for (int b = 0; b < 2; b++) begin
                inc = t.issue && !stall && t.dused && (t.dvec == b[0]);
                dec = b == 1 ? t.vwbe : t.wbe;
                if (dec && cnt[b][t.wbidx] == 0) merr = 1'b1;
                if (!(inc && dec && t.didx == t.wbidx)) begin
                    if (inc && cnt[b][t.didx] < 3) cnt[b][t.didx]++;
                    if (dec && cnt[b][t.wbidx] > 0) cnt[b][t.wbidx]--;
                end
            end
            if (t.wbe) ms[t.wbidx] = t.wbd;
            if (t.vwbe) mv[t.wbidx] = t.vwbd;
        end
    endtask

    task automatic step();
        obs_t e;
        e = predict(s);
        if (mdl_ok) exp_q.push_back(e);
        @(negedge clk);
        got = '{stall: o_stall, err: o_err, s1: o_s1, s2: o_s2, v1: o_v1, v2: o_v2};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "/stall"}, 64'(got.stall), 64'(e.stall));
            chk({tag, "/wberr"}, 64'(got.err), 64'(e.err));
            chk({tag, "/src1"}, 64'(got.s1), 64'(e.s1));
            chk({tag, "/src2"}, 64'(got.s2), 64'(e.s2));
            chk({tag, "/vsrc1"}, got.v1, e.v1);
            chk({tag, "/vsrc2"}, got.v2, e.v2);
        end
        @(posedge clk);
        apply(s, e.stall);
        #1;
    endtask

    initial begin
        s = idle();
        s.rst = 1'b1;
        @(posedge clk);
        #1;
        tag = "reset";
        step();
        s = idle();
        s.issue = 1'b1; s.s1used = 1'b1; s.dused = 1'b1;
        step();
        chk("reset_stall", 64'(got.stall), 64'd0);
        chk("reset_err", 64'(got.err), 64'd0);
        chk("reset_data", got.v1, 64'd0);

        tag = "wb_no_issue";
        s = idle();
        s.wbe = 1'b1; s.wbidx = 4'd3; s.wbd = 16'h1234;
        step();
        s = idle();
        s.s1idx = 4'd3;
        step();
        chk("wb_no_issue_err", 64'(got.err), 64'd1);
        chk("wb_no_issue_r3", 64'(got.s1), 64'h1234);

        tag = "raw";
        s = idle(); s.rst = 1'b1;
        step();
        s = idle(); s.issue = 1'b1; s.dused = 1'b1; s.didx = 4'd5;
        step();
        s = idle(); s.issue = 1'b1; s.s1used = 1'b1; s.s1idx = 4'd5;
        step();
        chk("raw_stall", 64'(got.stall), 64'd1);
        step();
        s.wbe = 1'b1; s.wbidx = 4'd5; s.wbd = 16'h00AA;
        step();
        chk("raw_release", 64'(got.stall), 64'd0);
        chk("raw_bypass", 64'(got.s1), 64'h00AA);

        tag = "waw_sat";
        s = idle(); s.issue = 1'b1; s.dused = 1'b1; s.dvec = 1'b1; s.didx = 4'd2;
        repeat (3) step();
        step();
        chk("waw_sat_stall", 64'(got.stall), 64'd1);
        s.vwbe = 1'b1; s.wbidx = 4'd2; s.vwbd = 64'hDEAD_BEEF_0000_0002;
        step();
        s.vwbe = 1'b0;
        step();
        chk("waw_sat_accept", 64'(got.stall), 64'd0);
        s = idle(); s.vwbe = 1'b1; s.wbidx = 4'd2; s.vwbd = 64'h0123_4567_89AB_CDEF;
        repeat (3) step();

        tag = "inc_dec";
        s = idle(); s.issue = 1'b1; s.dused = 1'b1; s.didx = 4'd7;
        step();
        s.wbe = 1'b1; s.wbidx = 4'd7; s.wbd = 16'h7777;
        step();
        chk("inc_dec_accept", 64'(got.stall), 64'd0);
        s = idle(); s.issue = 1'b1; s.s1used = 1'b1; s.s1idx = 4'd7;
        step();
        chk("inc_dec_hold", 64'(got.stall), 64'd1);
        s = idle(); s.wbe = 1'b1; s.wbidx = 4'd7; s.wbd = 16'h7778;
        step();

        tag = "lock";
        s = idle(); s.lock = 1'b0; s.issue = 1'b1; s.dused = 1'b1; s.didx = 4'd1;
        s.wbe = 1'b1; s.wbidx = 4'd1; s.wbd = 16'hBEEF;
        step();
        s = idle(); s.issue = 1'b1; s.s1used = 1'b1; s.s1idx = 4'd1;
        step();
        chk("lock_stall", 64'(got.stall), 64'd0);
        chk("lock_data", 64'(got.s1), 64'd0);
        chk("lock_err", 64'(got.err), 64'd0);

        tag = "mid_reset";
        s = idle(); s.issue = 1'b1; s.dused = 1'b1; s.dvec = 1'b1; s.didx = 4'd9;
        step();
        s = idle(); s.rst = 1'b1; s.issue = 1'b1; s.dused = 1'b1; s.dvec = 1'b1; s.didx = 4'd9;
        step();
        s = idle(); s.issue = 1'b1; s.s1used = 1'b1; s.s1vec = 1'b1; s.s1idx = 4'd9;
        step();
        chk("mid_reset_clear", 64'(got.stall), 64'd0);
        s = idle(); s.vwbe = 1'b1; s.wbidx = 4'd9; s.vwbd = 64'h1;
        step();
        s = idle(); s.s1idx = 4'd9;
        step();
        chk("mid_reset_err", 64'(got.err), 64'd1);
        chk("mid_reset_v9", got.v1, 64'h1);

        tag = "random";
        for (int n = 0; n < 400; n++) begin
            s.rst    = $urandom_range(0, 63) == 0;
            s.lock   = $urandom_range(0, 7) != 0;
            s.issue  = $urandom_range(0, 1) == 1;
            s.dused  = $urandom_range(0, 3) != 0;
            s.dvec   = $urandom_range(0, 1) == 1;
            s.s1used = $urandom_range(0, 1) == 1;
            s.s1vec  = $urandom_range(0, 1) == 1;
            s.s2used = $urandom_range(0, 1) == 1;
            s.s2vec  = $urandom_range(0, 1) == 1;
            s.wbe    = $urandom_range(0, 2) == 0;
            s.vwbe   = $urandom_range(0, 2) == 0;
            s.didx   = 4'($urandom_range(0, 3));
            s.s1idx  = 4'($urandom_range(0, 3));
            s.s2idx  = 4'($urandom_range(0, 3));
            s.wbidx  = 4'($urandom_range(0, 3));
            s.wbhi   = 2'($urandom_range(0, 3));
            s.wbd    = 16'($urandom);
            s.vwbd   = {32'($urandom), 32'($urandom)};
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
